vga_capture_rx: RTL and testbench
=================================

Name: vga_capture_rx

Overview:
- Receiving end of the team's VGA pixel stream. Samples r/g/b/hsync/vsync from a VGA source on pclk.
- Recovers the pixel coordinates and a pixel-valid strobe, and measures the line length and frame height.
- Reports a lock flag so downstream blocks (frame buffer writer, checker) consume only stable video.

Parameters:
- H_ACTIVE, 800, active dots per line
- H_BACK, 88, dots from hsync deassert (rising edge) to first active dot
- V_ACTIVE, 600, active lines per frame
- V_BACK, 23, lines from the first hsync assertion after vsync deassert to the first active line
- CW, 12, width of all counters and measurement outputs
- TIMEOUT, 4095, dots without an hsync assertion before sync is declared lost

Ports:
- pclk  in  1  pixel clock; all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- r_in  in  5  red input
- g_in  in  5  green input
- b_in  in  5  blue input
- hsync_in  in  1  horizontal sync, active low
- vsync_in  in  1  vertical sync, active low
- pix_valid  out  1  current outputs are an active pixel
- pix_x  out  CW  active column, 0..H_ACTIVE-1
- pix_y  out  CW  active row, 0..V_ACTIVE-1
- pix_r / pix_g / pix_b  out  5 each  captured colour
- frame_start  out  1  one-cycle pulse with pixel (0,0)
- line_len  out  CW  measured dots between consecutive hsync assertions
- frame_lines  out  CW  measured lines between consecutive vsync assertions
- locked  out  1  timing stable

Behaviour:
- Clock and reset: one clock (pclk). Reset is asynchronous, active-low (rst_n).
- Reset values: all outputs 0, all counters 0, sync history registers 1 (deasserted). Reset mid-frame discards all state; lock is reacquired from scratch.
- Stage 1 (input capture): register all inputs every posedge. Inputs are driven on negedge by the source.
- Stage 2 (edge detect): compare stage 1 with its delayed copy.
  - hs_fall = prev 1, now 0.
  - hs_rise = prev 0, now 1.
  - vs_fall / vs_rise defined the same way on vsync.
- Horizontal:
  - dot counter dc increments every cycle, saturating at 2^CW-1.
  - On hs_fall: line_len <= dc+1, dc <= 0.
  - Position counter hp resets to 0 on hs_rise and increments otherwise, saturating.
  - Column is active when H_BACK <= hp < H_BACK+H_ACTIVE; pix_x = hp-H_BACK.
- Vertical:
  - line counter lc increments on each hs_fall. On vs_fall: frame_lines <= lc, lc <= 0.
  - vs_rise sets vpend.
  - At the next hs_fall: vp <= 0 and vpend clears. Any other hs_fall increments vp, saturating.
  - Row is active when V_BACK <= vp < V_BACK+V_ACTIVE; pix_y = vp-V_BACK.
- hs_fall and vs_fall in the same cycle: the line is counted first (lc+1 stored), then lc clears.
- Output stage:
  - pix_valid = row active AND column active AND locked.
  - pix_x, pix_y and the colour outputs are registered together with pix_valid.
  - Latency is 2 posedges from input sample to outputs.
  - When pix_valid=0, pix_x, pix_y and colour hold 0.
- frame_start is asserted when pix_valid=1, pix_x=0 and pix_y=0.
- Lock state machine:
  - States: SEARCH, CHECK, LOCK.
  - SEARCH: first vs_fall → CHECK, store ref_len and ref_lines.
  - CHECK: next vs_fall with line_len==ref_len and frame_lines==ref_lines → LOCK. On mismatch, re-store the references and stay in CHECK.
  - LOCK: locked=1. Any hs_fall whose measured length ≠ ref_len → SEARCH, and locked drops the next cycle. A vs_fall with frame_lines ≠ ref_lines → SEARCH.
  - Loss of sync: dc reaching TIMEOUT with no hs_fall forces SEARCH and sets line_len=0 from any state.
- Arithmetic: all counters are unsigned CW bits and saturate; they never wrap.

Test Plan:
- 800x600 source, line 1056 dots, frame 628 lines, hsync 128 dots, vsync 4 lines → line_len=1056 and frame_lines=628 after the first full frame. locked=1 after the 2nd vs_fall. pix_valid is asserted exactly 480000 times per locked frame.
- Locked stream, r=x[4:0]: first valid pixel appears 88 dots after the hsync rise (plus 2-cycle latency) with pix_x=0 and pix_r matching. Last pixel of the row has pix_x=799. frame_start pulses once per frame, at (0,0).
- Hold hsync_in high for 5000 cycles while locked → at dc=4095, locked=0 and line_len=0. Restore the stream → locked=1 again after two matching frames.
- Change line length to 1057 mid-frame while locked → locked=0 the cycle after that hs_fall. Pixels stop; relock occurs at the new length.
- Assert rst_n=0 at pixel (400,300) → all outputs 0 immediately (asynchronously). Release → no pix_valid until two full frames have been observed.
- vsync assertion coincident with hs_fall → frame_lines=628, not 627. Row counting is unaffected.

Source files
------------

// File: rtl/vga_capture_rx.sv
// VGA receiver: recovers pixel position/valid, measures line/frame timing, tracks lock.
// Latency: 2 pclk edges from input sample to pix_* outputs.
// Backpressure: none; free-running video stream, every dot is consumed.
module vga_capture_rx #(
    parameter int H_ACTIVE = 800,
    parameter int H_BACK   = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_BACK   = 23,
    parameter int CW       = 12,
    parameter int TIMEOUT  = 4095
) (
    input  logic          pclk,
    input  logic          rst_n,
    input  logic [4:0]    r_in,
    input  logic [4:0]    g_in,
    input  logic [4:0]    b_in,
    input  logic          hsync_in,
    input  logic          vsync_in,
    output logic          pix_valid,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    output logic [4:0]    pix_r,
    output logic [4:0]    pix_g,
    output logic [4:0]    pix_b,
    output logic          frame_start,
    output logic [CW-1:0] line_len,
    output logic [CW-1:0] frame_lines,
    output logic          locked
);

    localparam logic [CW-1:0] H_LO = CW'(H_BACK);
    localparam logic [CW-1:0] H_HI = CW'(H_BACK + H_ACTIVE);
    localparam logic [CW-1:0] V_LO = CW'(V_BACK);
    localparam logic [CW-1:0] V_HI = CW'(V_BACK + V_ACTIVE);
    localparam logic [CW-1:0] TO   = CW'(TIMEOUT);

    typedef enum logic [1:0] {SEARCH, CHECK, LOCK} state_t;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    logic [4:0]    s1_r, s1_g, s1_b;
    logic          s1_hs, s1_vs, s2_hs, s2_vs;
    logic [CW-1:0] dc, hp, lc, vp;
    logic          vpend;
    logic [CW-1:0] ref_len, ref_lines;
    state_t        state, state_nxt;
    logic [CW-1:0] ref_len_nxt, ref_lines_nxt;

    logic          hs_fall, hs_rise, vs_fall, vs_rise;
    logic [CW-1:0] dc_inc, len_meas, lines_meas, hp_cur, vp_cur;
    logic          timeout, col_act, row_act, pix_ok;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r  <= '0;
            s1_g  <= '0;
            s1_b  <= '0;
            s1_hs <= 1'b1;
            s1_vs <= 1'b1;
            s2_hs <= 1'b1;
            s2_vs <= 1'b1;
        end else begin
            s1_r  <= r_in;
            s1_g  <= g_in;
            s1_b  <= b_in;
            s1_hs <= hsync_in;
            s1_vs <= vsync_in;
            s2_hs <= s1_hs;
            s2_vs <= s1_vs;
        end
    end

    assign hs_fall = s2_hs & ~s1_hs;
    assign hs_rise = ~s2_hs & s1_hs;
    assign vs_fall = s2_vs & ~s1_vs;
    assign vs_rise = ~s2_vs & s1_vs;

    // Measurements include the line closed by a coincident hs_fall.
    assign dc_inc     = sat_inc(dc);
    assign len_meas   = hs_fall ? dc_inc : line_len;
    assign lines_meas = hs_fall ? sat_inc(lc) : lc;
    assign timeout    = !hs_fall && (dc >= TO);

    // Position of the dot currently held in stage 1.
    assign hp_cur  = hs_rise ? '0 : sat_inc(hp);
    assign vp_cur  = hs_fall ? (vpend ? '0 : sat_inc(vp)) : vp;
    assign col_act = (hp_cur >= H_LO) && (hp_cur < H_HI);
    assign row_act = (vp_cur >= V_LO) && (vp_cur < V_HI);
    assign locked  = (state == LOCK);
    assign pix_ok  = col_act && row_act && locked;

    always_comb begin
        state_nxt     = state;
        ref_len_nxt   = ref_len;
        ref_lines_nxt = ref_lines;
        if (timeout) begin
            state_nxt = SEARCH;
        end else begin
            case (state)
                SEARCH: begin
                    if (vs_fall) begin
                        state_nxt     = CHECK;
                        ref_len_nxt   = len_meas;
                        ref_lines_nxt = lines_meas;
                    end
                end
                CHECK: begin
                    if (vs_fall) begin
                        if (len_meas == ref_len && lines_meas == ref_lines) begin
                            state_nxt = LOCK;
                        end else begin
                            ref_len_nxt   = len_meas;
                            ref_lines_nxt = lines_meas;
                        end
                    end
                end
                LOCK: begin
                    if ((hs_fall && dc_inc != ref_len) ||
                        (vs_fall && lines_meas != ref_lines)) begin
                        state_nxt = SEARCH;
                    end
                end
                default: state_nxt = SEARCH;
            endcase
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SEARCH;
            ref_len     <= '0;
            ref_lines   <= '0;
            dc          <= '0;
            hp          <= '0;
            lc          <= '0;
            vp          <= '0;
            vpend       <= 1'b0;
            line_len    <= '0;
            frame_lines <= '0;
        end else begin
            state       <= state_nxt;
            ref_len     <= ref_len_nxt;
            ref_lines   <= ref_lines_nxt;
            dc          <= hs_fall ? '0 : dc_inc;
            hp          <= hp_cur;
            vp          <= vp_cur;
            lc          <= vs_fall ? '0 : lines_meas;
            line_len    <= timeout ? '0 : len_meas;
            frame_lines <= vs_fall ? lines_meas : frame_lines;
            if (vs_rise)
                vpend <= 1'b1;
            else if (hs_fall)
                vpend <= 1'b0;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_r       <= '0;
            pix_g       <= '0;
            pix_b       <= '0;
            frame_start <= 1'b0;
        end else begin
            pix_valid   <= pix_ok;
            pix_x       <= pix_ok ? hp_cur - H_LO : '0;
            pix_y       <= pix_ok ? vp_cur - V_LO : '0;
            pix_r       <= pix_ok ? s1_r : '0;
            pix_g       <= pix_ok ? s1_g : '0;
            pix_b       <= pix_ok ? s1_b : '0;
            frame_start <= pix_ok && (hp_cur == H_LO) && (vp_cur == V_LO);
        end
    end

endmodule

// File: tb/tb_vga_capture_rx.sv
// Bench for vga_capture_rx on a reduced video timing: 8x4 active, 20-dot lines, 10-line frames.
module tb_vga_capture_rx;

    localparam int CW = 12;

    logic          pclk = 1'b0;
    logic          rst_n;
    logic [4:0]    r_in, g_in, b_in;
    logic          hsync_in, vsync_in;
    logic          pix_valid, frame_start, locked;
    logic [CW-1:0] pix_x, pix_y, line_len, frame_lines;
    logic [4:0]    pix_r, pix_g, pix_b;

    vga_capture_rx #(
        .H_ACTIVE(8), .H_BACK(3), .V_ACTIVE(4), .V_BACK(2), .CW(CW), .TIMEOUT(60)
    ) dut (
        .pclk(pclk), .rst_n(rst_n),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .frame_start(frame_start), .line_len(line_len),
        .frame_lines(frame_lines), .locked(locked)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        int         x;
        int         y;
        logic [4:0] r;
        logic [4:0] g;
        logic [4:0] b;
        bit         fs;
        int         t;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   npix = 0;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every valid pixel must match the oldest expected one.
    always @(negedge pclk) begin
        if (pix_valid === 1'b1) begin
            chk("sb_nonempty", q.size() != 0, 1);
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                chk("pix_x", pix_x, e.x);
                chk("pix_y", pix_y, e.y);
                chk("pix_rgb", {pix_r, pix_g, pix_b}, {e.r, e.g, e.b});
                chk("frame_start", frame_start, e.fs);
                chk("latency", cyc, e.t);
            end
            npix++;
        end else begin
            chk("idle_zero", {pix_x, pix_y, pix_r, pix_g, pix_b, frame_start}, 0);
        end
    end

    task automatic drive_dot(input bit hs, input bit vs, input int line, input int dot,
                             input bit push);
        exp_t e;
        @(negedge pclk);
        hsync_in = hs;
        vsync_in = vs;
        r_in     = 5'(dot);
        g_in     = 5'(line);
        b_in     = 5'(dot ^ (line * 3));
        if (push) begin
            e.x  = dot - 6;
            e.y  = line - 5;
            e.r  = 5'(dot);
            e.g  = 5'(line);
            e.b  = 5'(dot ^ (line * 3));
            e.fs = (dot == 6) && (line == 5);
            e.t  = cyc + 2;
            q.push_back(e);
        end
    endtask

    task automatic drive_idle(input int n);
        for (int i = 0; i < n; i++) drive_dot(1'b1, 1'b1, 0, 0, 1'b0);
    endtask

    // Frame: hsync low dots 0..2, vsync low from line 0 dot 0 to line 2 dot 9.
    // Active dots 6..13 of lines 5..8 when the receiver is expected to be locked.
    task automatic drive_frame(input int len_a, input int len_b, input int sw_line,
                               input bit exp_lock, input int probe_line, input int rst_line);
        bit lock_now = exp_lock;
        for (int line = 0; line < 10; line++) begin
            int len = (line >= sw_line) ? len_b : len_a;
            for (int dot = 0; dot < len; dot++) begin
                bit hs  = (dot >= 3);
                bit vs  = !(line < 2 || (line == 2 && dot < 10));
                bit act = lock_now && line >= 5 && line <= 8 && dot >= 6 && dot <= 13;
                drive_dot(hs, vs, line, dot, act);
                if (line == probe_line && dot == 1) chk("lock_held_at_fall", locked, 1);
                if (line == probe_line && dot == 2) chk("lock_drop_after_fall", locked, 0);
                if (line == rst_line && dot == 9) begin
                    #2 rst_n = 1'b0;
                    #1;
                    chk("arst_valid", pix_valid, 0);
                    chk("arst_locked", locked, 0);
                    chk("arst_meas", {line_len, frame_lines}, 0);
                    chk("arst_pix", {pix_x, pix_y, pix_r, frame_start}, 0);
                    q.delete();
                    lock_now = 1'b0;
                end
                if (line == rst_line && dot == 12) #2 rst_n = 1'b1;
            end
        end
        if (lock_now) chk("pix_count", npix, 32);
        chk("sb_drained", q.size(), 0);
        npix = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        r_in     = '0;
        g_in     = '0;
        b_in     = '0;
        repeat (3) @(negedge pclk);
        chk("rst_valid", pix_valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_line_len", line_len, 0);
        chk("rst_frame_lines", frame_lines, 0);
        chk("rst_frame_start", frame_start, 0);
        rst_n = 1'b1;
        drive_idle(4);

        // Acquire: two frames to measure, locked from the third.
        drive_frame(20, 20, 99, 0, -1, -1);
        drive_frame(20, 20, 99, 0, -1, -1);
        chk("meas_line_len", line_len, 20);
        chk("meas_frame_lines", frame_lines, 10);
        chk("not_yet_locked", locked, 0);
        drive_frame(20, 20, 99, 1, -1, -1);
        chk("locked", locked, 1);
        drive_frame(20, 20, 99, 1, -1, -1);

        // Loss of hsync.
        drive_idle(30);
        chk("lock_before_timeout", locked, 1);
        drive_idle(70);
        chk("timeout_unlock", locked, 0);
        chk("timeout_line_len", line_len, 0);
        drive_frame(20, 20, 99, 0, -1, -1);
        drive_frame(20, 20, 99, 0, -1, -1);
        drive_frame(20, 20, 99, 1, -1, -1);
        chk("relock_after_timeout", locked, 1);

        // Line length change mid-frame.
        drive_frame(20, 21, 4, 0, 5, -1);
        chk("unlocked_on_len_change", locked, 0);
        drive_frame(21, 21, 99, 0, -1, -1);
        drive_frame(21, 21, 99, 1, -1, -1);
        chk("relock_len", line_len, 21);
        chk("relock_new_len", locked, 1);

        // Reset in the middle of the active area.
        drive_frame(21, 21, 99, 1, -1, 6);
        drive_frame(21, 21, 99, 0, -1, -1);
        drive_frame(21, 21, 99, 0, -1, -1);
        chk("post_rst_unlocked", locked, 0);
        drive_frame(21, 21, 99, 1, -1, -1);
        chk("post_rst_locked", locked, 1);
        chk("final_frame_lines", frame_lines, 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
